// File: rtl/decoder_il_stage.sv
// decoder_il_stage: one-entry registered decoder for OP-IMM, LOAD and OP-IMM-32 with illegal counting.
`ifndef DECODER_OPER_DEFS
`define DECODER_OPER_DEFS
`define OPER_T logic [4:0]
`define OP_NOP    5'd0
`define OP_ADDI   5'd1
`define OP_SLTI   5'd2
`define OP_SLTIU  5'd3
`define OP_XORI   5'd4
`define OP_ORI    5'd5
`define OP_ANDI   5'd6
`define OP_SLLI   5'd7
`define OP_SRLI   5'd8
`define OP_SRAI   5'd9
`define OP_LB     5'd10
`define OP_LH     5'd11
`define OP_LW     5'd12
`define OP_LBU    5'd13
`define OP_LHU    5'd14
`define OP_LWU    5'd15
`define OP_LD     5'd16
`define OP_ADDIW  5'd17
`define OP_SLLIW  5'd18
`define OP_SRLIW  5'd19
`define OP_SRAIW  5'd20
`endif

module decoder_il_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output `OPER_T           op,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic [2:0]       f3;
  logic             sh_ok, is_sh, dec_ill, in_xfer, out_xfer;
  logic [XLEN-1:0]  sext, zsh, dec_imm;
  `OPER_T           dec_op;
  logic             valid_d, valid_q, ill_d, ill_q;
  `OPER_T           op_d, op_q;
  logic [XLEN-1:0]  imm_d, imm_q;
  logic [4:0]       rs1_d, rs1_q, rd_d, rd_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign f3    = inst[14:12];
  assign sext  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  // legal shifts always have inst[25]=0 except RV64 6-bit shamt, so one extension covers all
  assign zsh   = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign sh_ok = (XLEN == 64) || !inst[25];

  always_comb begin
    dec_op = `OP_NOP;
    is_sh  = 1'b0;
    case (inst[6:0])
      7'b0010011: case (f3)
        3'b000: dec_op = `OP_ADDI;
        3'b010: dec_op = `OP_SLTI;
        3'b011: dec_op = `OP_SLTIU;
        3'b100: dec_op = `OP_XORI;
        3'b110: dec_op = `OP_ORI;
        3'b111: dec_op = `OP_ANDI;
        3'b001: begin
          is_sh  = 1'b1;
          dec_op = (sh_ok && inst[31:26] == 6'b000000) ? `OP_SLLI : `OP_NOP;
        end
        3'b101: begin
          is_sh  = 1'b1;
          dec_op = !sh_ok ? `OP_NOP :
                   inst[31:26] == 6'b000000 ? `OP_SRLI :
                   inst[31:26] == 6'b010000 ? `OP_SRAI : `OP_NOP;
        end
        default: ;
      endcase
      7'b0000011: case (f3)
        3'b000: dec_op = `OP_LB;
        3'b001: dec_op = `OP_LH;
        3'b010: dec_op = `OP_LW;
        3'b100: dec_op = `OP_LBU;
        3'b101: dec_op = `OP_LHU;
        3'b110: dec_op = (XLEN == 64) ? `OP_LWU : `OP_NOP;
        3'b011: dec_op = (XLEN == 64) ? `OP_LD : `OP_NOP;
        default: ;
      endcase
      7'b0011011: if (XLEN == 64) case (f3)
        3'b000: dec_op = `OP_ADDIW;
        3'b001: begin
          is_sh  = 1'b1;
          dec_op = (inst[31:25] == 7'b0000000) ? `OP_SLLIW : `OP_NOP;
        end
        3'b101: begin
          is_sh  = 1'b1;
          dec_op = inst[31:25] == 7'b0000000 ? `OP_SRLIW :
                   inst[31:25] == 7'b0100000 ? `OP_SRAIW : `OP_NOP;
        end
        default: ;
      endcase
      default: ;
    endcase
  end

  assign dec_ill  = (dec_op == `OP_NOP);
  assign dec_imm  = dec_ill ? '0 : is_sh ? zsh : sext;
  assign in_ready = !flush && (!valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  always_comb begin
    valid_d = flush ? 1'b0 : in_xfer ? 1'b1 : out_xfer ? 1'b0 : valid_q;
    op_d    = in_xfer ? dec_op : op_q;
    imm_d   = in_xfer ? dec_imm : imm_q;
    rs1_d   = in_xfer ? inst[19:15] : rs1_q;
    rd_d    = in_xfer ? inst[11:7] : rd_q;
    ill_d   = in_xfer ? dec_ill : ill_q;
    cnt_d   = (in_xfer && dec_ill && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= `OP_NOP;
      imm_q   <= '0;
      rs1_q   <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign op          = op_q;
  assign imm         = imm_q;
  assign rs1         = rs1_q;
  assign rd          = rd_q;
  assign illegal     = ill_q;
  assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decoder_il_stage.sv
// tb_decoder_il_stage: directed checks of an RV32 (2-bit counter) and an RV64 instance driven in parallel.
module tb_decoder_il_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] inst = '0;
  logic        ir32, ov32, il32, ir64, ov64, il64;
  logic [4:0]  op32, op64, rs1_32, rd32, rs1_64, rd64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [1:0]  cnt32;
  logic [15:0] cnt64;
  int checks = 0, errors = 0;

  decoder_il_stage #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32), .inst(inst),
    .out_valid(ov32), .out_ready(out_ready), .op(op32), .imm(imm32), .rs1(rs1_32), .rd(rd32),
    .illegal(il32), .illegal_cnt(cnt32));

  decoder_il_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64), .inst(inst),
    .out_valid(ov64), .out_ready(out_ready), .op(op64), .imm(imm64), .rs1(rs1_64), .rd(rd64),
    .illegal(il64), .illegal_cnt(cnt64));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [4:0] e_op, input logic [31:0] e_imm,
                       input logic [4:0] e_rs1, input logic [4:0] e_rd, input logic e_il);
    check({tag, ".v32"}, ov32, 1);
    check({tag, ".op32"}, op32, e_op);
    check({tag, ".imm32"}, imm32, e_imm);
    check({tag, ".rs1_32"}, rs1_32, e_rs1);
    check({tag, ".rd32"}, rd32, e_rd);
    check({tag, ".il32"}, il32, e_il);
  endtask

  task automatic chk64(input string tag, input logic [4:0] e_op, input logic [63:0] e_imm, input logic e_il);
    check({tag, ".v64"}, ov64, 1);
    check({tag, ".op64"}, op64, e_op);
    check({tag, ".imm64"}, imm64, e_imm);
    check({tag, ".il64"}, il64, e_il);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".v32"}, ov32, 0);
    check({tag, ".op32"}, op32, `OP_NOP);
    check({tag, ".imm32"}, imm32, 0);
    check({tag, ".rs1"}, rs1_32, 0);
    check({tag, ".rd"}, rd32, 0);
    check({tag, ".il32"}, il32, 0);
    check({tag, ".cnt32"}, cnt32, 0);
    check({tag, ".v64"}, ov64, 0);
    check({tag, ".imm64"}, imm64, 0);
    check({tag, ".cnt64"}, cnt64, 0);
  endtask

  initial begin
    #2 chk_reset("reset");
    step;
    rst = 1'b0;
    check("ready_after_rst", ir32, 1);
    in_valid = 1'b1;
    inst = 32'hFFF00093; step;
    chk32("addi", `OP_ADDI, 32'hFFFFFFFF, 0, 1, 0);
    chk64("addi", `OP_ADDI, 64'hFFFFFFFFFFFFFFFF, 0);
    inst = 32'h40335293; step;
    chk32("srai", `OP_SRAI, 3, 6, 5, 0);
    check("cnt32_0", cnt32, 0);
    inst = 32'hC0335293; step;
    chk32("srai_bad", `OP_NOP, 0, 6, 5, 1);
    chk64("srai_bad", `OP_NOP, 0, 1);
    check("cnt32_1", cnt32, 1);
    check("cnt64_1", cnt64, 1);
    inst = 32'h02009093; step;
    chk32("slli32", `OP_NOP, 0, 1, 1, 1);
    chk64("slli64", `OP_SLLI, 32, 0);
    check("cnt32_2", cnt32, 2);
    inst = 32'hFFF1009B; step;
    chk32("addiw32", `OP_NOP, 0, 2, 1, 1);
    chk64("addiw", `OP_ADDIW, 64'hFFFFFFFFFFFFFFFF, 0);
    check("cnt32_3", cnt32, 3);
    inst = 32'h00813183; step;
    chk32("ld32", `OP_NOP, 0, 2, 3, 1);
    chk64("ld", `OP_LD, 8, 0);
    check("cnt32_sat1", cnt32, 3);
    inst = 32'h4030D29B; step;
    chk64("sraiw", `OP_SRAIW, 3, 0);
    check("cnt32_sat2", cnt32, 3);
    check("cnt64_keep", cnt64, 1);
    inst = 32'hFFC0A203; step;
    chk32("lw", `OP_LW, 32'hFFFFFFFC, 1, 4, 0);
    chk64("lw", `OP_LW, 64'hFFFFFFFFFFFFFFFC, 0);
    inst = 32'h0F01F113;
    out_ready = 1'b0;
    #1 check("hold_ready", ir32, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      check("hold_ready_c", ir32, 0);
      chk32("hold", `OP_LW, 32'hFFFFFFFC, 1, 4, 0);
    end
    out_ready = 1'b1;
    #1 check("release_ready", ir32, 1);
    step;
    chk32("andi", `OP_ANDI, 32'h000000F0, 3, 2, 0);
    inst = 32'h00116193;
    out_ready = 1'b0;
    flush = 1'b1;
    #1 check("flush_ready", ir32, 0);
    step;
    check("flush_v", ov32, 0);
    check("flush_op", op32, `OP_ANDI);
    check("flush_cnt", cnt32, 3);
    flush = 1'b0;
    #1 check("post_flush_ready", ir32, 1);
    step;
    chk32("ori", `OP_ORI, 1, 2, 3, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    check("drain_v", ov32, 0);
    in_valid = 1'b1;
    inst = 32'hC0335293;
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_v", ov32, 1);
    check("pre_rst_cnt64", cnt64, 2);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    step;
    rst = 1'b0;
    check("rst_rel_ready", ir32, 1);
    flush = 1'b1;
    #1 check("rst_rel_flush_ready", ir32, 0);
    flush = 1'b0;
    step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_il_stage.md
DECODER_IL_STAGE -- requirements
Module: decoder_il_stage

Interface
- REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
- REQ-002 Parameter CNT_W, default 16, width of the illegal-instruction counter.
- REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
- REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
- REQ-005 Port flush, input, 1, discards the held entry and blocks acceptance this cycle.
- REQ-006 Port in_valid, input, 1, inst is valid.
- REQ-007 Port in_ready, output, 1, the stage accepts inst this cycle.
- REQ-008 Port inst, input, 32, raw instruction word.
- REQ-009 Port out_valid, output, 1, the registered decode result is valid.
- REQ-010 Port out_ready, input, 1, the consumer takes the result this cycle.
- REQ-011 Port op, output, `oper_t, operation code.
- REQ-012 Port imm, output, XLEN, immediate.
- REQ-013 Port rs1, output, 5, inst[19:15].
- REQ-014 Port rd, output, 5, inst[11:7].
- REQ-015 Port illegal, output, 1, the held entry is undecodable.
- REQ-016 Port illegal_cnt, output, CNT_W, saturating count of accepted illegal instructions.

Function
- REQ-017 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- REQ-018 in_ready SHALL be !flush && (!out_valid || out_ready), combinationally.
- REQ-019 Latency is 1 cycle: a word accepted in cycle N is presented at out_valid, op, imm, rs1 and rd in cycle N+1.
- REQ-020 While out_valid=1 and out_ready=0, op, imm, rs1, rd and illegal SHALL hold stable.
- REQ-021 out_valid next state: 0 if flush; else 1 on an input transfer; else 0 on an output transfer; otherwise unchanged.
- REQ-022 An output transfer and an input transfer in the same cycle SHALL replace the entry with no bubble.
- REQ-023 Opcode 0010011 (OP-IMM), decoded by funct3:
  - 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
  - For all of these, imm = sign-extended inst[31:20] to XLEN.
  - 001 SLLI: requires funct7[6:1]=000000.
  - 101 SRLI when inst[31:26]=000000; SRAI when inst[31:26]=010000.
  - Shifts: imm = zero-extended shamt.
- REQ-024 Shamt width: RV32 uses inst[24:20], and inst[25]=1 is illegal; RV64 uses inst[25:20].
- REQ-025 Opcode 0000011 (LOAD), decoded by funct3:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - XLEN=64 additionally: 110 LWU, 011 LD.
  - imm = sign-extended inst[31:20].
- REQ-026 Opcode 0011011 (OP-IMM-32), legal only when XLEN=64:
  - 000 ADDIW, imm sign-extended.
  - 001 SLLIW, requires inst[31:25]=0000000.
  - 101 SRLIW when inst[31:25]=0000000; SRAIW when inst[31:25]=0100000.
  - *W shifts: imm = zero-extended inst[24:20].
- REQ-027 Any other opcode, funct3 or funct7 combination is illegal.
- REQ-028 An illegal entry registers op=OP_NOP, imm=0 and illegal=1; rs1 and rd are still registered from inst.
- REQ-029 illegal_cnt SHALL increment by 1 on each input transfer with an illegal decode, saturating at all-ones.
- REQ-030 OP_LWU, OP_LD, OP_ADDIW, OP_SLLIW, OP_SRLIW and OP_SRAIW SHALL be added to the shared operation defines; existing codes are unchanged.
- REQ-031 Payload registers SHALL load only on an input transfer; flush SHALL NOT alter the payload or illegal_cnt.

Reset
- REQ-032 While rst=1, regardless of clk, the outputs SHALL be:
  - out_valid=0, op=OP_NOP, imm=0, rs1=0, rd=0;
  - illegal=0, illegal_cnt=0.
- REQ-033 A reset asserted mid-hold SHALL drop the held entry; the first cycle after deassertion has in_ready=!flush.

Verification
- REQ-034 XLEN=32, inst=0xFFF00093 accepted with out_ready=1 -> next cycle: out_valid=1, op=OP_ADDI, imm=0xFFFFFFFF, rs1=0, rd=1, illegal=0.
- REQ-035 inst=0x40335293 -> op=OP_SRAI, imm=3, rs1=6, rd=5; the same word with inst[31:26]=110000 -> illegal=1, op=OP_NOP, illegal_cnt+1.
- REQ-036 inst=0x02009093 (shamt 32):
  - XLEN=32 -> illegal=1, imm=0;
  - XLEN=64 -> op=OP_SLLI, imm=32.
- REQ-037 Hold out_ready=0 for 3 cycles with a second word pending -> in_ready=0 and outputs frozen; raise out_ready -> the second word appears the next cycle with no bubble.
- REQ-038 flush=1 with in_valid=1 while holding -> in_ready=0; next cycle out_valid=0; the pending word is not consumed.
- REQ-039 CNT_W=2, five illegal words accepted -> illegal_cnt sequence 1,2,3,3,3; assert rst asynchronously mid-hold -> all outputs reach reset values before the next clk edge.
